// File: rtl/bcd_seq_adder_pkg.sv
// bcd_seq_adder_pkg: shared FSM state encoding and BCD constants
package bcd_seq_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;
endpackage

// File: rtl/bcd_seq_adder_if.sv
// bcd_seq_adder_if: start/operand request and sum/status response bundle; master drives start,a,b,ci, slave drives busy,done,sum,co,err
interface bcd_seq_adder_if #(parameter int DIGITS = 4);
  logic start;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic ci;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] sum;
  logic co;
  logic err;
  modport master(output start, a, b, ci, input busy, done, sum, co, err);
  modport slave(input start, a, b, ci, output busy, done, sum, co, err);
endinterface

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one-digit BCD adder (a, b, ci in; corrected digit s and carry co out)
module bcd_digit_add
  import bcd_seq_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] t;
  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    co = t > {1'b0, DIGIT_MAX};
    s = co ? t[3:0] + BCD_CORR : t[3:0];
  end
endmodule

// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: digit-serial BCD adder (clk, rst, bus slave: start/a/b/ci in, busy/done/sum/co/err out)
module bcd_seq_adder
  import bcd_seq_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  bcd_seq_adder_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, co_q, co_d, err_q, err_d, busy_q, busy_d, done_q, done_d, bad;
  logic [3:0] dig_s;
  logic dig_c;
  bcd_digit_add u_add (
    .a (a_q[4*idx_q +: 4]),
    .b (b_q[4*idx_q +: 4]),
    .ci(carry_q),
    .s (dig_s),
    .co(dig_c)
  );
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (bus.a[4*i +: 4] > DIGIT_MAX) | (bus.b[4*i +: 4] > DIGIT_MAX);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    idx_d = idx_q;
    carry_d = carry_q;
    co_d = co_q;
    err_d = err_q;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      a_d = bus.a;
      b_d = bus.b;
      carry_d = bus.ci;
      idx_d = '0;
      sum_d = '0;
      err_d = bad;
    end else if (state_q == RUN) begin
      sum_d[4*idx_q +: 4] = dig_s;
      carry_d = dig_c;
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(DIGITS - 1)) begin
        state_d = DONE;
        co_d = dig_c;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      co_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      co_q <= co_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum = sum_q;
  assign bus.co = co_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder: table-driven and scoreboarded checks of bcd_seq_adder at DIGITS=4 and DIGITS=1
module tb_bcd_seq_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bcd_seq_adder_if #(.DIGITS(4)) bus4 ();
  bcd_seq_adder_if #(.DIGITS(1)) bus1 ();
  bcd_seq_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  bcd_seq_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        err;
    bit          poke;
  } vec_t;
  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        err;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[9];
  int tests = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  task automatic run4(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                      input exp_t e, input bit poke);
    int n;
    int nb;
    exp_t got;
    sb.push_back(e);
    @(negedge clk);
    bus4.a = av;
    bus4.b = bv;
    bus4.ci = cv;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.a = ~av;
    bus4.b = 16'h1111;
    bus4.ci = ~cv;
    n = 1;
    nb = 0;
    while (!bus4.done && n < 20) begin
      if (bus4.busy) nb++;
      bus4.start = poke && n == 2;
      @(negedge clk);
      n++;
    end
    bus4.start = 1'b0;
    if (!bus4.done) begin
      tests++;
      bad++;
      $display("FAIL timeout: no done within %0d cycles", n);
    end
    chk("latency", n, 5);
    chk("busy_cycles", nb, 4);
    chk("busy_at_done", bus4.busy, 0);
    got = sb.pop_front();
    chk("sum", bus4.sum, got.sum);
    chk("co", bus4.co, got.co);
    chk("err", bus4.err, got.err);
    @(negedge clk);
    chk("done_single", bus4.done, 0);
    chk("idle_after", bus4.busy, 0);
    chk("sum_hold", bus4.sum, got.sum);
  endtask
  initial begin
    vecs[0] = '{16'h0001, 16'h0006, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0077, 16'h0008, 1'b0, 16'h0085, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h5000, 16'h5000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h0009, 16'hF000, 1'b0, 16'h5009, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b0};
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.ci = 1'b0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.ci = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum", bus4.sum, 0);
    chk("rst_co", bus4.co, 0);
    chk("rst_err", bus4.err, 0);
    chk("rst_busy", bus4.busy, 0);
    chk("rst_done", bus4.done, 0);
    rst = 1'b0;
    foreach (vecs[i]) run4(vecs[i].a, vecs[i].b, vecs[i].ci,
                           '{vecs[i].sum, vecs[i].co, vecs[i].err}, vecs[i].poke);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] av, bv;
      logic cv;
      int s;
      for (int d = 0; d < 4; d++) begin
        av[4*d +: 4] = 4'($urandom_range(0, 9));
        bv[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      cv = 1'($urandom_range(0, 1));
      s = bcd2int(av) + bcd2int(bv) + int'(cv);
      run4(av, bv, cv, '{int2bcd(s % 10000), s >= 10000, 1'b0}, 1'b0);
    end
    run4(16'h9999, 16'h9999, 1'b1, '{16'h9999, 1'b1, 1'b0}, 1'b0);
    @(negedge clk);
    bus4.a = 16'hFFFF;
    bus4.b = 16'hFFFF;
    bus4.ci = 1'b1;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", bus4.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sum", bus4.sum, 0);
    chk("abort_co", bus4.co, 0);
    chk("abort_err", bus4.err, 0);
    chk("abort_busy", bus4.busy, 0);
    chk("abort_done", bus4.done, 0);
    begin
      int seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus4.done) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    run4(16'h0002, 16'h0002, 1'b1, '{16'h0005, 1'b0, 1'b0}, 1'b0);
    @(negedge clk);
    bus1.a = 4'h7;
    bus1.b = 4'h8;
    bus1.ci = 1'b0;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("d1_busy", bus1.busy, 1);
    chk("d1_done_early", bus1.done, 0);
    @(negedge clk);
    chk("d1_done", bus1.done, 1);
    chk("d1_sum", bus1.sum, 4'h5);
    chk("d1_co", bus1.co, 1);
    chk("d1_err", bus1.err, 0);
    @(negedge clk);
    chk("d1_done_single", bus1.done, 0);
    $display("test done: total=%0d bad=%0d", tests, bad);
    $finish;
  end
endmodule

// File: doc/bcd_seq_adder.md
BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port a  input  4*DIGITS  operand A; digit i occupies bits [4i+3:4i], digit 0 is least significant.
REQ-006 Port b  input  4*DIGITS  operand B; same packing as a.
REQ-007 Port ci  input  1  carry into digit 0.
REQ-008 Port busy  output  1  high while digits are being processed (state RUN).
REQ-009 Port done  output  1  one-cycle pulse when sum, co and err are valid.
REQ-010 Port sum  output  4*DIGITS  BCD result; same packing as a.
REQ-011 Port co  output  1  carry out of the most significant digit.
REQ-012 Port err  output  1  high if any operand digit latched at start exceeded 9.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL capture a, b and ci into internal registers, clear the digit index to 0, clear sum, latch err, and enter RUN.
REQ-015 err SHALL be set if any captured digit of a or b is greater than 9 (values 10..15), and SHALL be cleared otherwise.
REQ-016 Each edge in RUN SHALL process exactly one digit i, least significant first, as follows:
- t = A_i + B_i + carry, as a 5-bit quantity;
- if t > 9: sum digit i = (t + 6) mod 16 and carry = 1;
- otherwise: sum digit i = t and carry = 0.
REQ-017 The rule in REQ-016 SHALL be applied unchanged to invalid digits; the result is deterministic and is flagged by err.
REQ-018 The carry used for digit 0 SHALL be the captured ci.
REQ-019 After digit DIGITS-1 is processed, the FSM SHALL enter DONE and co SHALL take the final carry at that same edge.
REQ-020 Latency: if start is sampled at edge E0, done SHALL be high in the cycle following edge E(DIGITS) and low at every other time.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-022 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-023 start SHALL be ignored in RUN and DONE, and captured operands SHALL NOT change while busy.
REQ-024 Changes on a, b or ci after capture SHALL NOT affect the result.
REQ-025 sum, co and err SHALL hold their last values in IDLE until the next accepted start.
REQ-026 Partial sum digits MAY be visible during RUN; they are defined as valid only while done is high and afterwards.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, sum=0, co=0, err=0, with the digit index and internal carry cleared.
REQ-028 rst SHALL take priority over start and over any operation in progress.
REQ-029 A reset asserted mid-RUN SHALL abort the addition with no done pulse.
REQ-030 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-031 A shared package/header SHALL hold:
- the state encodings IDLE, RUN and DONE;
- the BCD constants DIGIT_MAX = 9 and BCD_CORR = 6.
REQ-032 A combinational sub-module bcd_digit_add SHALL implement the one-digit adder: inputs (4b, 4b, carry), outputs (4-bit digit, carry). It SHALL be instantiated once and shared across all digits.
REQ-033 The digit index SHALL be a counter of width clog2(DIGITS), minimum 1 bit.

Verification
REQ-034 DIGITS=4, a=0x0001, b=0x0006, ci=1 -> done after 4 cycles; sum=0x0008, co=0, err=0.
REQ-035 DIGITS=4, a=0x9999, b=0x0001, ci=0 -> sum=0x0000, co=1, err=0; busy high for exactly 4 cycles.
REQ-036 DIGITS=4, a=0x0077, b=0x0008, ci=0 -> sum=0x0085, co=0; a second start pulsed during busy is ignored, yielding a single done pulse.
REQ-037 DIGITS=4, a=0x000A, b=0x0000, ci=0 -> err=1, sum=0x0010, co=0.
REQ-038 rst asserted on the 2nd RUN cycle -> no done pulse and all outputs 0 the next cycle; a new start with a=0x0002, b=0x0002, ci=1 -> sum=0x0005.
REQ-039 DIGITS=1, a=0x7, b=0x8, ci=0 -> done 1 cycle after start, sum=0x5, co=1.
